// File: rtl/binary_to_gray_pkg.sv
// Shared constants and conversion helpers for the binary/Gray converter.
// Helpers operate on 32-bit zero-extended values, so narrower callers truncate the result.
package binary_to_gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrow values intact.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
        logic [MAX_WIDTH-1:0] bin;
        bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
        for (int k = MAX_WIDTH-2; k >= 0; k--) begin
            bin[k] = bin[k+1] ^ gray[k];
        end
        return bin;
    endfunction

endpackage

// File: rtl/binary_to_gray_gray_to_binary.sv
// Combinational Gray-to-binary decoder used by the optional output self-check.
module gray_to_binary
    import binary_to_gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);

    logic [MAX_WIDTH-1:0] w_gray_ext;
    logic [MAX_WIDTH-1:0] w_binary_ext;

    assign w_gray_ext   = MAX_WIDTH'(i_gray);
    assign w_binary_ext = gray2bin(w_gray_ext);
    assign o_binary     = w_binary_ext[WIDTH-1:0];

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter, one cycle latency, async active-high reset.
// Define BINARY_TO_GRAY_SELFCHECK_EN to add o_mismatch, a decode-and-compare check of o_gray.
module binary_to_gray
    import binary_to_gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_binary,
`ifdef BINARY_TO_GRAY_SELFCHECK_EN
    output logic             o_mismatch,
`endif
    output logic [WIDTH-1:0] o_gray
);

    logic [MAX_WIDTH-1:0] w_gray_ext;
    logic [WIDTH-1:0]     w_gray_next;
    logic [WIDTH-1:0]     r_gray;

    assign w_gray_ext  = bin2gray(MAX_WIDTH'(i_binary));
    assign w_gray_next = w_gray_ext[WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gray <= '0;
        end else begin
            r_gray <= w_gray_next;
        end
    end

    assign o_gray = r_gray;

`ifdef BINARY_TO_GRAY_SELFCHECK_EN
    logic [WIDTH-1:0] r_bin_hold;
    logic [WIDTH-1:0] w_decoded;
    logic             r_mismatch;

    gray_to_binary #(
        .WIDTH (WIDTH)
    ) u_gray_to_binary (
        .i_gray   (r_gray),
        .o_binary (w_decoded)
    );

    // r_bin_hold is captured on the same edge as r_gray so the pair is always coherent.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin_hold <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_bin_hold <= i_binary;
            r_mismatch <= (w_decoded != r_bin_hold);
        end
    end

    assign o_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed testbench for binary_to_gray (WIDTH=4), one line per transaction.
// Self-check scenarios are compiled in when BINARY_TO_GRAY_SELFCHECK_EN is defined.
module tb_binary_to_gray;
    import binary_to_gray_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
`ifdef BINARY_TO_GRAY_SELFCHECK_EN
    logic         mismatch;
`endif

    int n_pass  = 0;
    int n_total = 0;

    binary_to_gray #(
        .WIDTH (W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_binary   (bin),
`ifdef BINARY_TO_GRAY_SELFCHECK_EN
        .o_mismatch (mismatch),
`endif
        .o_gray     (gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived Gray codes for 0..15.
    logic [W-1:0] gray_table [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    task automatic test_reset();
        rst = 1'b1;
        bin = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (gray !== 4'b0000)
                $display("FAIL reset_hold cycle %0d: got %b expected 0000", i, gray);
            else begin
                n_pass++;
                $display("reset_hold cycle %0d: o_gray=%b", i, gray);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (gray !== 4'b1111)
            $display("FAIL reset_release: got %b expected 1111", gray);
        else begin
            n_pass++;
            $display("reset_release: bin=1010 o_gray=%b", gray);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] vin  [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1000, 4'b1111};
        logic [W-1:0] vexp [5] = '{4'b0000, 4'b0010, 4'b0111, 4'b1100, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            bin = vin[i];
            @(posedge clk); #1;
            n_total++;
            if (gray !== vexp[i])
                $display("FAIL directed bin=%b: got %b expected %b", vin[i], gray, vexp[i]);
            else begin
                n_pass++;
                $display("directed: bin=%b o_gray=%b", vin[i], gray);
            end
        end
    endtask

    task automatic test_sweep_wrap();
        logic [W-1:0] prev;
        logic [W-1:0] exp_g;
        prev = 'x;
        for (int i = 0; i <= 16; i++) begin
            bin   = W'(i % 16);
            exp_g = gray_table[i % 16];
            @(posedge clk); #1;
            n_total++;
            if (gray !== exp_g)
                $display("FAIL sweep bin=%b: got %b expected %b", bin, gray, exp_g);
            else begin
                n_pass++;
                $display("sweep: bin=%b o_gray=%b", bin, gray);
            end
            if (i > 0) begin
                n_total++;
                if ($countones(prev ^ gray) != 1)
                    $display("FAIL one_bit_step %b->%b: bits changed %0d expected 1",
                             prev, gray, $countones(prev ^ gray));
                else
                    n_pass++;
            end
            prev = gray;
        end
    endtask

    task automatic test_latency();
        bin = 4'b0110;
        @(posedge clk); #1;
        n_total++;
        if (gray !== 4'b0101)
            $display("FAIL latency_first: got %b expected 0101", gray);
        else begin
            n_pass++;
            $display("latency: bin=0110 o_gray=%b", gray);
        end
        bin = 4'b1001;
        #3;
        n_total++;
        if (gray !== 4'b0101)
            $display("FAIL latency_hold: got %b expected 0101", gray);
        else begin
            n_pass++;
            $display("latency: bin changed to 1001 mid-cycle, o_gray=%b", gray);
        end
        @(posedge clk); #1;
        n_total++;
        if (gray !== 4'b1101)
            $display("FAIL latency_update: got %b expected 1101", gray);
        else begin
            n_pass++;
            $display("latency: bin=1001 o_gray=%b", gray);
        end
    endtask

    task automatic test_async_reset();
        bin = 4'b1111;
        @(posedge clk); #1;
        n_total++;
        if (gray !== 4'b1000)
            $display("FAIL async_pre: got %b expected 1000", gray);
        else
            n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (gray !== 4'b0000)
            $display("FAIL async_clear: got %b expected 0000", gray);
        else begin
            n_pass++;
            $display("async_reset: pulse between edges, o_gray=%b", gray);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (gray !== 4'b1000)
            $display("FAIL async_resume: got %b expected 1000", gray);
        else begin
            n_pass++;
            $display("async_reset: resumed bin=1111 o_gray=%b", gray);
        end
    endtask

`ifdef BINARY_TO_GRAY_SELFCHECK_EN
    task automatic test_selfcheck();
        logic [MAX_WIDTH-1:0] dec;
        for (int i = 0; i < 16; i++) begin
            bin = W'(i);
            @(posedge clk); #1;
            dec = gray2bin(MAX_WIDTH'(gray));
            n_total++;
            if (mismatch !== 1'b0 || dec[W-1:0] !== W'(i))
                $display("FAIL selfcheck_sweep bin=%b: mismatch=%b decoded=%b expected 0/%b",
                         bin, mismatch, dec[W-1:0], bin);
            else begin
                n_pass++;
                $display("selfcheck: bin=%b o_gray=%b o_mismatch=%b", bin, gray, mismatch);
            end
        end
        bin = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        force dut.r_gray = 4'b0111;
        #2;
        release dut.r_gray;
        @(posedge clk); #1;
        n_total++;
        if (mismatch !== 1'b1)
            $display("FAIL selfcheck_inject: got %b expected 1", mismatch);
        else begin
            n_pass++;
            $display("selfcheck: corrupted o_gray bit0, o_mismatch=%b", mismatch);
        end
        @(posedge clk); #1;
        n_total++;
        if (mismatch !== 1'b0)
            $display("FAIL selfcheck_recover: got %b expected 0", mismatch);
        else
            n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bin = '0;
        test_reset();
        test_directed();
        test_sweep_wrap();
        test_latency();
        test_async_reset();
`ifdef BINARY_TO_GRAY_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
